// File: rtl/screen_pkg.sv
// screen_pkg: shared definitions for the screen controller.
//   state_t    - top-level FSM encoding
//   scr_sel_t  - which full-screen drawer owns the VGA port
//   *_DEF      - default colours and draw watchdog limit
//   is_draw()  - true for the three DRAW_* states
package screen_pkg;

    typedef enum logic [2:0] {
        ST_DRAW_TITLE = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_PLAY       = 3'd2,
        ST_DRAW_WIN   = 3'd3,
        ST_DRAW_LOSE  = 3'd4,
        ST_HOLD       = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SEL_TITLE = 2'd0,
        SEL_WIN   = 2'd1,
        SEL_LOSE  = 2'd2
    } scr_sel_t;

    localparam logic [2:0] TITLE_FG_DEF = 3'b110;
    localparam logic [2:0] WIN_FG_DEF   = 3'b010;
    localparam logic [2:0] LOSE_FG_DEF  = 3'b100;
    localparam logic [2:0] BG_DEF       = 3'b000;
    localparam int         WDOG_MAX_DEF = 20480;

    function automatic logic is_draw(input state_t s);
        return (s == ST_DRAW_TITLE) || (s == ST_DRAW_WIN) || (s == ST_DRAW_LOSE);
    endfunction

endpackage

// File: rtl/pixel_pipe.sv
// pixel_pipe: one register stage that delays the active drawer's x/y, the
// pixel-valid flag and the screen select, so they line up with the colour
// bit coming out of the drawer's synchronous ROM one cycle later.
// Ports:
//   clk, reset        - clock, synchronous active-high reset (valid only)
//   i_vld/i_x/i_y/i_sel - pixel from the active drawer, this cycle
//   o_vld/o_x/o_y/o_sel - same pixel, one cycle later
module pixel_pipe
    import screen_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       i_vld,
    input  logic [7:0] i_x,
    input  logic [6:0] i_y,
    input  scr_sel_t   i_sel,
    output logic       o_vld,
    output logic [7:0] o_x,
    output logic [6:0] o_y,
    output scr_sel_t   o_sel
);

    logic       r_vld_p1;
    logic [7:0] r_x_p1;
    logic [6:0] r_y_p1;
    scr_sel_t   r_sel_p1;

    // p0 -> p1: drawer address stage to ROM data stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
        end
    end

    // Data is qualified by r_vld_p1 downstream, so it needs no reset.
    always_ff @(posedge clk) begin
        r_x_p1   <= i_x;
        r_y_p1   <= i_y;
        r_sel_p1 <= i_sel;
    end

    assign o_vld = r_vld_p1;
    assign o_x   = r_x_p1;
    assign o_y   = r_y_p1;
    assign o_sel = r_sel_p1;

endmodule

// File: rtl/screen_ctrl.sv
// screen_ctrl: sequences the title / gameplay / win / lose screens, hands the
// VGA port to the active full-screen drawer or to gameplay, and guards every
// screen draw with a watchdog.
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   game_start/game_win/game_lose - level-sampled game events
//   en_title/en_win/en_lose     - drawer enables (registered)
//   t_*/w_*/l_*                 - drawer x, y, colour bit, done
//   game_en                     - gameplay owns the VGA port
//   vga_x/vga_y/vga_colour/plot - pixel write to the VGA adapter
//   busy                        - a screen is being drawn
//   wdog_err                    - sticky: a draw hit the watchdog limit
module screen_ctrl
    import screen_pkg::*;
#(
    parameter logic [2:0] TITLE_FG = TITLE_FG_DEF,
    parameter logic [2:0] WIN_FG   = WIN_FG_DEF,
    parameter logic [2:0] LOSE_FG  = LOSE_FG_DEF,
    parameter logic [2:0] BG       = BG_DEF,
    parameter int         WDOG_MAX = WDOG_MAX_DEF
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       game_start,
    input  logic       game_win,
    input  logic       game_lose,
    output logic       en_title,
    output logic       en_win,
    output logic       en_lose,
    input  logic [7:0] t_x,
    input  logic [6:0] t_y,
    input  logic       t_c,
    input  logic       t_done,
    input  logic [7:0] w_x,
    input  logic [6:0] w_y,
    input  logic       w_c,
    input  logic       w_done,
    input  logic [7:0] l_x,
    input  logic [6:0] l_y,
    input  logic       l_c,
    input  logic       l_done,
    output logic       game_en,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       wdog_err
);

    localparam int WD_W = $clog2(WDOG_MAX + 1);

    state_t          r_state;
    state_t          w_next;
    logic [WD_W-1:0] r_wdog;

    logic       w_in_draw;
    logic       w_act_en;
    logic       w_act_done;
    logic       w_wdog_hit;
    logic       w_exit;
    logic       w_pix_vld;
    logic [7:0] w_src_x;
    logic [6:0] w_src_y;
    scr_sel_t   w_src_sel;

    logic       w_vld_p1;
    logic [7:0] w_x_p1;
    logic [6:0] w_y_p1;
    scr_sel_t   w_sel_p1;
    logic       w_cbit;
    logic [2:0] w_fg;

    // Active drawer mux, driven by the current state.
    always_comb begin
        w_act_en   = 1'b0;
        w_act_done = 1'b0;
        w_src_x    = '0;
        w_src_y    = '0;
        w_src_sel  = SEL_TITLE;
        case (r_state)
            ST_DRAW_TITLE: begin
                w_act_en   = en_title;
                w_act_done = t_done;
                w_src_x    = t_x;
                w_src_y    = t_y;
                w_src_sel  = SEL_TITLE;
            end
            ST_DRAW_WIN: begin
                w_act_en   = en_win;
                w_act_done = w_done;
                w_src_x    = w_x;
                w_src_y    = w_y;
                w_src_sel  = SEL_WIN;
            end
            ST_DRAW_LOSE: begin
                w_act_en   = en_lose;
                w_act_done = l_done;
                w_src_x    = l_x;
                w_src_y    = l_y;
                w_src_sel  = SEL_LOSE;
            end
            default: ;
        endcase
    end

    assign w_in_draw  = is_draw(r_state);
    assign w_wdog_hit = w_in_draw && (r_wdog == WD_W'(WDOG_MAX - 1));
    assign w_exit     = w_in_draw && (w_act_done || w_wdog_hit);
    // The pixel of a watchdog-forced exit is dropped too: it would otherwise
    // land in a non-drawing state.
    assign w_pix_vld  = w_act_en && !w_act_done && !w_wdog_hit;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_DRAW_TITLE: if (w_exit) w_next = ST_WAIT_START;
            ST_WAIT_START: if (game_start) w_next = ST_PLAY;
            ST_PLAY: begin
                if (game_win)       w_next = ST_DRAW_WIN;
                else if (game_lose) w_next = ST_DRAW_LOSE;
            end
            ST_DRAW_WIN:   if (w_exit) w_next = ST_HOLD;
            ST_DRAW_LOSE:  if (w_exit) w_next = ST_HOLD;
            ST_HOLD:       if (game_start) w_next = ST_DRAW_TITLE;
            default:       w_next = ST_DRAW_TITLE;
        endcase
    end

    // Outputs are registered from the next state so they track r_state
    // cycle for cycle; reset holds them low for one extra cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_DRAW_TITLE;
            en_title <= 1'b0;
            en_win   <= 1'b0;
            en_lose  <= 1'b0;
            game_en  <= 1'b0;
            busy     <= 1'b0;
            wdog_err <= 1'b0;
            r_wdog   <= '0;
        end else begin
            r_state  <= w_next;
            en_title <= (w_next == ST_DRAW_TITLE);
            en_win   <= (w_next == ST_DRAW_WIN);
            en_lose  <= (w_next == ST_DRAW_LOSE);
            game_en  <= (w_next == ST_PLAY);
            busy     <= is_draw(w_next);
            r_wdog   <= (w_in_draw && !w_exit) ? r_wdog + 1'b1 : '0;
            if (w_wdog_hit && !w_act_done) begin
                wdog_err <= 1'b1;
            end
        end
    end

    pixel_pipe u_pipe (
        .clk   (clk),
        .reset (reset),
        .i_vld (w_pix_vld),
        .i_x   (w_src_x),
        .i_y   (w_src_y),
        .i_sel (w_src_sel),
        .o_vld (w_vld_p1),
        .o_x   (w_x_p1),
        .o_y   (w_y_p1),
        .o_sel (w_sel_p1)
    );

    // ROM colour bit arrives now, aligned with the delayed x/y.
    always_comb begin
        w_cbit = 1'b0;
        w_fg   = BG;
        case (w_sel_p1)
            SEL_TITLE: begin w_cbit = t_c; w_fg = TITLE_FG; end
            SEL_WIN:   begin w_cbit = w_c; w_fg = WIN_FG;   end
            SEL_LOSE:  begin w_cbit = l_c; w_fg = LOSE_FG;  end
            default: ;
        endcase
    end

    assign plot       = w_vld_p1;
    assign vga_x      = w_vld_p1 ? w_x_p1 : '0;
    assign vga_y      = w_vld_p1 ? w_y_p1 : '0;
    assign vga_colour = (w_vld_p1 && w_cbit) ? w_fg : BG;

endmodule
